// File: rtl/hex_display_scanner.sv
// Scans an N-digit common-anode 7-segment display: one digit per slot, nibble to hex7seg.
// Latency: outputs are combinational from registered state; a new value shows from the next frame.
// Backpressure: one pending buffer; value_ready_o is low until the frame boundary empties it.
//
// Ports:
//   clk_i, rst_i                  clock and synchronous active-high reset
//   value_i / value_valid_i /     hex value offered for display (nibble k -> digit k),
//   value_ready_o                 transferred on valid & ready
//   blank_lz_i                    blank leading zero digits (digit 0 never blanked)
//   dp_i                          decimal-point request per digit
//   digit_o                       nibble of the active digit (to hex7seg d3..d0)
//   anode_no, dp_no               active-low anode enables and decimal point
//   digit_idx_o                   current slot index
module hex_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter int GUARD_CYCLES   = 500
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    value_valid_i,
    output logic                    value_ready_o,
    input  logic                    blank_lz_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [3:0]              digit_o,
    output logic [NUM_DIGITS-1:0]   anode_no,
    output logic                    dp_no,
    output logic [2:0]              digit_idx_o
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // With no guard interval every slot starts directly in DRIVE.
    localparam state_t SLOT_START = (GUARD_CYCLES == 0) ? S_DRIVE : S_GUARD;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              idx;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [4*NUM_DIGITS-1:0] pend;
    logic                    pend_full;

    logic slot_end;
    logic frame_end;
    logic accept;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign accept    = value_valid_i && !pend_full;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= SLOT_START;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_GUARD: if (cnt == GUARD_LAST) state_nxt = S_DRIVE;
            S_DRIVE: if (slot_end)          state_nxt = SLOT_START;
            default: state_nxt = SLOT_START;
        endcase
    end

    // Slot counter, digit index and the two value buffers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            idx       <= '0;
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A full pend cannot accept in the same cycle, so the boundary copy and
            // a new transfer never collide; a transfer on the boundary lands in pend only.
            if (frame_end && pend_full) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend      <= value_i;
                pend_full <= 1'b1;
            end
        end
    end

    // Output logic
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_run;
    logic                  cur_blank;
    logic                  cur_dp;
    logic                  drive_on;

    always_comb begin
        // Walk from the most significant digit down; a digit is a leading zero while
        // every nibble from it upward is zero.
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (disp[4*k +: 4] == 4'h0);
            blank_mask[k] = blank_lz_i && zero_run && (k > 0);
        end

        digit_o   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                digit_o   = disp[4*k +: 4];
                cur_blank = blank_mask[k];
                cur_dp    = dp_i[k];
            end
        end

        drive_on = (state == S_DRIVE) && !cur_blank;
        anode_no = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (drive_on && (idx == 3'(k))) anode_no[k] = 1'b0;
        end
        dp_no = drive_on ? !cur_dp : 1'b1;
    end

    assign value_ready_o = !pend_full;
    assign digit_idx_o   = idx;

endmodule

// File: tb/tb_hex_display_scanner.sv
`timescale 1ns/1ps
module tb_hex_display_scanner;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] value_i;
    logic        value_valid_i;
    logic        value_ready_o;
    logic        blank_lz_i;
    logic [3:0]  dp_i;
    logic [3:0]  digit_o;
    logic [3:0]  anode_no;
    logic        dp_no;
    logic [2:0]  digit_idx_o;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    hex_display_scanner #(
        .NUM_DIGITS    (4),
        .REFRESH_CYCLES(8),
        .GUARD_CYCLES  (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .value_i      (value_i),
        .value_valid_i(value_valid_i),
        .value_ready_o(value_ready_o),
        .blank_lz_i   (blank_lz_i),
        .dp_i         (dp_i),
        .digit_o      (digit_o),
        .anode_no     (anode_no),
        .dp_no        (dp_no),
        .digit_idx_o  (digit_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Advance to slot-relative cycle 'target' (counted from reset release); sample 1ns after the edge.
    task automatic go(input int target);
        while (t < target) begin
            @(posedge clk_i);
            #1;
            t++;
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        value_i       = 16'h0;
        value_valid_i = 1'b0;
        blank_lz_i    = 1'b0;
        dp_i          = 4'h0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        t     = 0;

        // Reset state
        chk("rst_anode", 16'(anode_no), 16'hF);
        chk("rst_dp", 16'(dp_no), 16'h1);
        chk("rst_ready", 16'(value_ready_o), 16'h1);
        chk("rst_idx", 16'(digit_idx_o), 16'h0);
        chk("rst_digit", 16'(digit_o), 16'h0);

        // First load goes to pend; frame 0 still shows zeros
        go(1);
        value_valid_i = 1'b1; value_i = 16'h12AB;
        go(2);
        value_valid_i = 1'b0;
        chk("f0_ready_low", 16'(value_ready_o), 16'h0);
        chk("f0_s0_anode", 16'(anode_no), 16'hE);
        chk("f0_s0_digit", 16'(digit_o), 16'h0);
        chk("f0_s0_dp", 16'(dp_no), 16'h1);
        go(10);
        chk("f0_s1_anode", 16'(anode_no), 16'hD);
        chk("f0_s1_digit", 16'(digit_o), 16'h0);
        chk("f0_s1_idx", 16'(digit_idx_o), 16'h1);
        go(31);
        chk("f0_end_ready", 16'(value_ready_o), 16'h0);
        chk("f0_end_idx", 16'(digit_idx_o), 16'h3);

        // Frame 1 shows 12AB; reload the same value
        go(32);
        chk("f1_ready", 16'(value_ready_o), 16'h1);
        chk("f1_guard0", 16'(anode_no), 16'hF);
        chk("f1_s0_digit", 16'(digit_o), 16'hB);
        value_valid_i = 1'b1; value_i = 16'h12AB;
        go(33);
        value_valid_i = 1'b0;
        chk("f1_guard1", 16'(anode_no), 16'hF);
        go(34);
        chk("f1_s0_anode", 16'(anode_no), 16'hE);
        chk("f1_s0_digitB", 16'(digit_o), 16'hB);
        go(42);
        chk("f1_s1_anode", 16'(anode_no), 16'hD);
        chk("f1_s1_digit", 16'(digit_o), 16'hA);
        go(50);
        chk("f1_s2_anode", 16'(anode_no), 16'hB);
        chk("f1_s2_digit", 16'(digit_o), 16'h2);
        go(58);
        chk("f1_s3_anode", 16'(anode_no), 16'h7);
        chk("f1_s3_digit", 16'(digit_o), 16'h1);
        dp_i = 4'h8;
        #1;
        chk("f1_s3_dp_on", 16'(dp_no), 16'h0);
        dp_i = 4'h0;

        // Load 0050 for the blanking frame
        go(64);
        chk("f2_digit", 16'(digit_o), 16'hB);
        chk("f2_ready", 16'(value_ready_o), 16'h1);
        value_valid_i = 1'b1; value_i = 16'h0050;
        go(65);
        value_valid_i = 1'b0;
        go(96);
        chk("f3_ready", 16'(value_ready_o), 16'h1);
        blank_lz_i = 1'b1;
        value_valid_i = 1'b1; value_i = 16'h0000;
        go(97);
        value_valid_i = 1'b0;
        go(98);
        chk("lz_s0_anode", 16'(anode_no), 16'hE);
        chk("lz_s0_digit", 16'(digit_o), 16'h0);
        go(106);
        chk("lz_s1_anode", 16'(anode_no), 16'hD);
        chk("lz_s1_digit", 16'(digit_o), 16'h5);
        go(114);
        dp_i = 4'h4;
        #1;
        chk("lz_s2_anode", 16'(anode_no), 16'hF);
        chk("lz_s2_dp", 16'(dp_no), 16'h1);
        dp_i = 4'h0;
        go(122);
        chk("lz_s3_anode", 16'(anode_no), 16'hF);

        // Frame shows 0000; offer 1111 then 2222 back to back
        go(128);
        chk("hs_ready0", 16'(value_ready_o), 16'h1);
        value_valid_i = 1'b1; value_i = 16'h1111;
        go(129);
        value_i = 16'h2222;
        go(130);
        chk("lz0_s0_anode", 16'(anode_no), 16'hE);
        chk("hs_ready_low", 16'(value_ready_o), 16'h0);
        go(138);
        chk("lz0_s1_anode", 16'(anode_no), 16'hF);
        blank_lz_i = 1'b0;
        #1;
        chk("nolz_s1_anode", 16'(anode_no), 16'hD);
        go(159);
        chk("hs_ready_bnd", 16'(value_ready_o), 16'h0);
        go(160);
        chk("hs_ready_back", 16'(value_ready_o), 16'h1);
        chk("hs_disp1111", 16'(digit_o), 16'h1);
        go(161);
        chk("hs_2222_taken", 16'(value_ready_o), 16'h0);
        value_valid_i = 1'b0;
        go(192);
        chk("hs_disp2222", 16'(digit_o), 16'h2);
        chk("hs_ready_f6", 16'(value_ready_o), 16'h1);

        // Offer exactly on the boundary cycle
        go(223);
        chk("bnd_ready", 16'(value_ready_o), 16'h1);
        value_valid_i = 1'b1; value_i = 16'h3333;
        go(224);
        value_valid_i = 1'b0;
        chk("bnd_disp_kept", 16'(digit_o), 16'h2);
        chk("bnd_pend_full", 16'(value_ready_o), 16'h0);
        go(256);
        chk("bnd_disp_next", 16'(digit_o), 16'h3);
        chk("bnd_ready_next", 16'(value_ready_o), 16'h1);

        // Reset mid-slot with pend full
        value_valid_i = 1'b1; value_i = 16'h4444;
        go(257);
        value_valid_i = 1'b0;
        go(277);
        chk("mr_pre_idx", 16'(digit_idx_o), 16'h2);
        chk("mr_pre_anode", 16'(anode_no), 16'hB);
        chk("mr_pre_ready", 16'(value_ready_o), 16'h0);
        rst_i = 1'b1;
        go(278);
        rst_i = 1'b0;
        t = 0;
        chk("mr_idx", 16'(digit_idx_o), 16'h0);
        chk("mr_anode", 16'(anode_no), 16'hF);
        chk("mr_ready", 16'(value_ready_o), 16'h1);
        chk("mr_digit", 16'(digit_o), 16'h0);
        go(2);
        chk("mr_s0_anode", 16'(anode_no), 16'hE);
        chk("mr_s0_digit", 16'(digit_o), 16'h0);
        go(34);
        chk("mr_f1_idx", 16'(digit_idx_o), 16'h0);
        chk("mr_f1_anode", 16'(anode_no), 16'hE);
        chk("mr_f1_digit", 16'(digit_o), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
